// File: rtl/pe_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_feeder_pkg
// Description : Shared state encoding, default sizes and pass-target helper
//               for the PE array feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_feeder_pkg;

   localparam int c_rows        = 12;
   localparam int c_data_w      = 16;
   localparam int c_filt_depth  = 256;
   localparam int c_ifmap_depth = 1024;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ALARM   = 3'd1,
      ST_STREAM  = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_FINISH  = 3'd4
   } feeder_state_e;

   // Number of sliding-window passes: max(W-S+1, 1), saturated to 16 bits.
   function automatic logic [15:0] pass_target(input logic [15:0] w, input logic [4:0] s);
      logic signed [17:0] diff;
      diff = $signed({2'b00, w}) - $signed({13'd0, s}) + 18'sd1;
      if (diff < 18'sd1)
         return 16'd1;
      else if (diff > 18'sd65535)
         return 16'hffff;
      else
         return diff[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/simple_dp_ram.sv
`default_nettype none
// ============================================================================
// Module      : simple_dp_ram
// Description : One write port, one registered read port; read-during-write
//               to the same address returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_dp_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (wr_en)
         r_mem[wr_addr] <= wr_data;
      if (rd_en)
         r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pe_array_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_feeder
// Description : Buffers host filter/ifmap words, streams them to the PE rows
//               under controller enables and times each compute pass.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array_feeder
   import pe_feeder_pkg::*;
#(
   parameter int DATA_W      = c_data_w,
   parameter int ROWS        = c_rows,
   parameter int FILT_DEPTH  = c_filt_depth,
   parameter int IFMAP_DEPTH = c_ifmap_depth
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              kick,
   input  logic [4:0]        S,
   input  logic [4:0]        q,
   input  logic [15:0]       W,
   input  logic [9:0]        compute_cycles,
   input  logic              buf_wr_en,
   input  logic              buf_sel,
   input  logic [9:0]        buf_wr_addr,
   input  logic [DATA_W-1:0] buf_wr_data,
   input  logic [ROWS-1:0]   load_signal2,
   input  logic [ROWS-1:0]   load_signal3,
   input  logic              start,
   output logic              alarm,
   output logic [DATA_W-1:0] filt_data,
   output logic              filt_valid,
   output logic [ROWS-1:0]   filt_row_en,
   output logic [DATA_W-1:0] ifmap_data,
   output logic              ifmap_valid,
   output logic [ROWS-1:0]   ifmap_row_en,
   output logic              complete,
   output logic              done
);

   localparam int c_fa = $clog2(FILT_DEPTH);
   localparam int c_ia = $clog2(IFMAP_DEPTH);

   feeder_state_e r_state, w_state_nxt;

   logic [c_fa-1:0]   r_filt_ptr;
   logic [c_ia-1:0]   r_ifmap_base, r_ifmap_off, w_ifmap_addr;
   logic [15:0]       r_pass_cnt;
   logic [9:0]        r_cnt;
   logic              r_start_d;
   logic              r_filt_valid, r_ifmap_valid;
   logic [ROWS-1:0]   r_filt_row_en, r_ifmap_row_en;
   logic [DATA_W-1:0] w_filt_q, w_ifmap_q;
   logic              w_filt_rd, w_ifmap_rd, w_start_rise, w_expire, w_last_pass, w_layer_start;

   assign w_ifmap_addr = r_ifmap_base + r_ifmap_off;

   always_comb begin
      w_filt_rd    = (r_state == ST_STREAM) && (|load_signal3);
      w_ifmap_rd   = (r_state == ST_STREAM) && !(|load_signal3) && (|load_signal2);
      w_start_rise = start && !r_start_d;
      w_expire     = (r_state == ST_COMPUTE) && (r_cnt == 10'd1);
      w_last_pass  = (r_pass_cnt + 16'd1) == pass_target(W, S);
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_layer_start = 1'b0;
      case (r_state)
         ST_IDLE, ST_FINISH: begin
            if (kick) begin
               w_state_nxt   = ST_ALARM;
               w_layer_start = 1'b1;
            end
         end
         ST_ALARM:   w_state_nxt = ST_STREAM;
         ST_STREAM:  if (w_start_rise) w_state_nxt = ST_COMPUTE;
         ST_COMPUTE: if (w_expire) w_state_nxt = w_last_pass ? ST_FINISH : ST_STREAM;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state        <= ST_IDLE;
         r_filt_ptr     <= '0;
         r_ifmap_base   <= '0;
         r_ifmap_off    <= '0;
         r_pass_cnt     <= '0;
         r_cnt          <= '0;
         r_start_d      <= 1'b0;
         r_filt_valid   <= 1'b0;
         r_ifmap_valid  <= 1'b0;
         r_filt_row_en  <= '0;
         r_ifmap_row_en <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_start_d      <= start;
         r_filt_valid   <= w_filt_rd;
         r_ifmap_valid  <= w_ifmap_rd;
         r_filt_row_en  <= w_filt_rd  ? load_signal3 : '0;
         r_ifmap_row_en <= w_ifmap_rd ? load_signal2 : '0;

         // A new layer (from IDLE or a re-kick out of FINISH) restarts all pointers.
         if ((r_state == ST_IDLE) || w_layer_start) begin
            r_filt_ptr   <= '0;
            r_ifmap_base <= '0;
            r_ifmap_off  <= '0;
            r_pass_cnt   <= '0;
         end
         if (w_filt_rd)
            r_filt_ptr <= r_filt_ptr + c_fa'(1);
         if (w_ifmap_rd)
            r_ifmap_off <= r_ifmap_off + c_ia'(1);

         if ((r_state == ST_STREAM) && w_start_rise)
            r_cnt <= (compute_cycles == '0) ? 10'd1 : compute_cycles;
         else if (r_state == ST_COMPUTE)
            r_cnt <= r_cnt - 10'd1;

         if (w_expire) begin
            r_pass_cnt   <= r_pass_cnt + 16'd1;
            r_ifmap_base <= r_ifmap_base + c_ia'(q);
            r_ifmap_off  <= '0;
         end
      end
   end

   simple_dp_ram #(.DATA_W(DATA_W), .DEPTH(FILT_DEPTH)) u_filt_ram (
      .clk     (clk),
      .wr_en   (buf_wr_en && !buf_sel),
      .wr_addr (buf_wr_addr[c_fa-1:0]),
      .wr_data (buf_wr_data),
      .rd_en   (w_filt_rd),
      .rd_addr (r_filt_ptr),
      .rd_data (w_filt_q)
   );

   simple_dp_ram #(.DATA_W(DATA_W), .DEPTH(IFMAP_DEPTH)) u_ifmap_ram (
      .clk     (clk),
      .wr_en   (buf_wr_en && buf_sel),
      .wr_addr (buf_wr_addr[c_ia-1:0]),
      .wr_data (buf_wr_data),
      .rd_en   (w_ifmap_rd),
      .rd_addr (w_ifmap_addr),
      .rd_data (w_ifmap_q)
   );

   // RAM outputs are unreset, so data is masked to zero when not valid.
   assign filt_data    = r_filt_valid  ? w_filt_q  : '0;
   assign ifmap_data   = r_ifmap_valid ? w_ifmap_q : '0;
   assign filt_valid   = r_filt_valid;
   assign ifmap_valid  = r_ifmap_valid;
   assign filt_row_en  = r_filt_row_en;
   assign ifmap_row_en = r_ifmap_row_en;
   assign alarm        = (r_state == ST_ALARM);
   assign done         = (r_state == ST_FINISH);
   assign complete     = w_expire;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_feeder
// Description : Directed self-checking bench for pe_array_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array_feeder;

   logic        clk = 1'b0;
   logic        rstn, kick, start, buf_wr_en, buf_sel;
   logic [4:0]  S, q;
   logic [15:0] W;
   logic [9:0]  compute_cycles, buf_wr_addr;
   logic [15:0] buf_wr_data;
   logic [11:0] load_signal2, load_signal3;
   logic        alarm, filt_valid, ifmap_valid, complete, done;
   logic [15:0] filt_data, ifmap_data;
   logic [11:0] filt_row_en, ifmap_row_en;

   int checks = 0;
   int passes = 0;

   pe_array_feeder dut (
      .clk(clk), .rstn(rstn), .kick(kick), .S(S), .q(q), .W(W),
      .compute_cycles(compute_cycles), .buf_wr_en(buf_wr_en), .buf_sel(buf_sel),
      .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .load_signal2(load_signal2), .load_signal3(load_signal3), .start(start),
      .alarm(alarm), .filt_data(filt_data), .filt_valid(filt_valid), .filt_row_en(filt_row_en),
      .ifmap_data(ifmap_data), .ifmap_valid(ifmap_valid), .ifmap_row_en(ifmap_row_en),
      .complete(complete), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_buf(input logic sel, input logic [9:0] addr, input logic [15:0] data);
      buf_wr_en = 1'b1; buf_sel = sel; buf_wr_addr = addr; buf_wr_data = data;
      tick();
      buf_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; kick = 0; start = 0; buf_wr_en = 0; buf_sel = 0; buf_wr_addr = '0;
      buf_wr_data = '0; load_signal2 = '0; load_signal3 = '0;
      S = 5'd3; W = 16'd5; q = 5'd2; compute_cycles = 10'd5;
      tick(); tick();
      checks++; if (alarm !== 1'b0) $display("FAIL reset_alarm: got %b want 0", alarm); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
      checks++; if (complete !== 1'b0) $display("FAIL reset_complete: got %b want 0", complete); else passes++;
      checks++; if ({filt_valid, ifmap_valid, filt_data, ifmap_data, filt_row_en, ifmap_row_en} !== '0)
         $display("FAIL reset_stream_outs: got %b %b %h %h %h %h want all 0", filt_valid, ifmap_valid,
                  filt_data, ifmap_data, filt_row_en, ifmap_row_en); else passes++;
      rstn = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) write_buf(1'b0, 10'(i), 16'(10 + i));
      for (int i = 0; i < 16; i++) write_buf(1'b1, 10'(i), 16'(100 + i));
   endtask

   task automatic test_alarm();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      checks++; if (alarm !== 1'b1) $display("FAIL alarm_pulse: got %b want 1", alarm); else passes++;
      tick();
      checks++; if (alarm !== 1'b0) $display("FAIL alarm_width: got %b want 0", alarm); else passes++;
   endtask

   task automatic test_filter_stream();
      load_signal3 = 12'hfff;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) load_signal3 = '0;
         checks++; if (filt_valid !== 1'b1 || filt_data !== 16'(10 + i) || filt_row_en !== 12'hfff)
            $display("FAIL filt_word%0d: got v=%b d=%0d en=%h want v=1 d=%0d en=fff",
                     i, filt_valid, filt_data, filt_row_en, 10 + i); else passes++;
      end
      tick();
      checks++; if (filt_valid !== 1'b0) $display("FAIL filt_valid_fall: got %b want 0", filt_valid); else passes++;
   endtask

   task automatic test_ifmap_stream(input int first);
      load_signal2 = 12'h007;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) load_signal2 = '0;
         checks++; if (ifmap_valid !== 1'b1 || ifmap_data !== 16'(first + i) || ifmap_row_en !== 12'h007)
            $display("FAIL ifmap_word%0d: got v=%b d=%0d en=%h want v=1 d=%0d en=007",
                     i, ifmap_valid, ifmap_data, ifmap_row_en, first + i); else passes++;
      end
      tick();
      checks++; if (ifmap_valid !== 1'b0) $display("FAIL ifmap_valid_fall: got %b want 0", ifmap_valid); else passes++;
   endtask

   task automatic test_compute(input logic [9:0] cycles, input int exp_lat, input logic exp_done);
      int n;
      compute_cycles = cycles;
      start = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (complete !== 1'b1 && n < 40);
      checks++; if (n !== exp_lat) $display("FAIL complete_latency: got %0d want %0d", n, exp_lat); else passes++;
      tick();
      start = 1'b0;
      checks++; if (complete !== 1'b0) $display("FAIL complete_width: got %b want 0", complete); else passes++;
      checks++; if (done !== exp_done) $display("FAIL done_after_pass: got %b want %b", done, exp_done); else passes++;
   endtask

   task automatic test_priority();
      load_signal3 = 12'hfff;
      load_signal2 = 12'h007;
      tick();
      load_signal3 = '0;
      checks++; if (filt_valid !== 1'b1 || filt_data !== 16'd14 || ifmap_valid !== 1'b0)
         $display("FAIL priority: got fv=%b fd=%0d iv=%b want fv=1 fd=14 iv=0",
                  filt_valid, filt_data, ifmap_valid); else passes++;
      load_signal2 = '0;
      test_ifmap_stream(102);
   endtask

   task automatic test_rw_collision();
      load_signal3 = 12'h001;
      buf_wr_en = 1'b1; buf_sel = 1'b0; buf_wr_addr = 10'd5; buf_wr_data = 16'd999;
      tick();
      buf_wr_en = 1'b0;
      load_signal3 = '0;
      checks++; if (filt_data !== 16'd15 || filt_row_en !== 12'h001)
         $display("FAIL rw_old_data: got d=%0d en=%h want d=15 en=001", filt_data, filt_row_en); else passes++;
      load_signal2 = 12'h001;
      tick();
      load_signal2 = '0;
      checks++; if (ifmap_data !== 16'd104)
         $display("FAIL pass3_base: got %0d want 104", ifmap_data); else passes++;
   endtask

   task automatic test_second_kick();
      tick();
      checks++; if (done !== 1'b1) $display("FAIL done_hold: got %b want 1", done); else passes++;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      checks++; if (alarm !== 1'b1 || done !== 1'b0)
         $display("FAIL rekick: got alarm=%b done=%b want alarm=1 done=0", alarm, done); else passes++;
      tick();
   endtask

   task automatic test_reset_midstream();
      load_signal3 = 12'hfff;
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      load_signal3 = '0;
      checks++; if ({alarm, done, complete, filt_valid, ifmap_valid, filt_data, filt_row_en} !== '0)
         $display("FAIL midstream_reset: got a=%b d=%b c=%b fv=%b iv=%b fd=%h en=%h want all 0",
                  alarm, done, complete, filt_valid, ifmap_valid, filt_data, filt_row_en); else passes++;
      tick();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      tick();
      load_signal3 = 12'hfff;
      tick();
      load_signal3 = '0;
      checks++; if (filt_data !== 16'd10) $display("FAIL intact_filt0: got %0d want 10", filt_data); else passes++;
      load_signal2 = 12'h004;
      tick();
      load_signal2 = '0;
      checks++; if (ifmap_data !== 16'd100 || ifmap_row_en !== 12'h004)
         $display("FAIL intact_ifmap0: got d=%0d en=%h want d=100 en=004", ifmap_data, ifmap_row_en); else passes++;
   endtask

   initial begin
      test_reset();
      test_alarm();
      test_filter_stream();
      test_ifmap_stream(100);
      test_compute(10'd5, 5, 1'b0);
      test_priority();
      test_compute(10'd0, 1, 1'b0);
      test_rw_collision();
      test_compute(10'd3, 3, 1'b1);
      test_second_kick();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
